// File: rtl/exin_axi_full_slave_mem_if.sv
// AXI4-full slave-side bundle for the Exin memory responder.
// Carries the AW/W/B/AR/R channel signals between the M0_AXI master and the memory.
interface exin_axi_full_slave_mem_if #(
  parameter int AW = 10,
  parameter int DW = 32
);
  logic [AW-1:0]   S_AXI_AWADDR;
  logic [7:0]      S_AXI_AWLEN;
  logic [1:0]      S_AXI_AWBURST;
  logic            S_AXI_AWVALID;
  logic            S_AXI_AWREADY;
  logic [DW-1:0]   S_AXI_WDATA;
  logic [DW/8-1:0] S_AXI_WSTRB;
  logic            S_AXI_WLAST;
  logic            S_AXI_WVALID;
  logic            S_AXI_WREADY;
  logic [1:0]      S_AXI_BRESP;
  logic            S_AXI_BVALID;
  logic            S_AXI_BREADY;
  logic [AW-1:0]   S_AXI_ARADDR;
  logic [7:0]      S_AXI_ARLEN;
  logic [1:0]      S_AXI_ARBURST;
  logic            S_AXI_ARVALID;
  logic            S_AXI_ARREADY;
  logic [DW-1:0]   S_AXI_RDATA;
  logic [1:0]      S_AXI_RRESP;
  logic            S_AXI_RLAST;
  logic            S_AXI_RVALID;
  logic            S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWBURST, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARBURST, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID,
    input  S_AXI_RREADY
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWBURST, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARBURST, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID,
    output S_AXI_RREADY
  );
endinterface

// File: rtl/exin_axi_full_slave_mem.sv
// AXI4-full word-wide memory slave: independent write/read burst engines,
// one outstanding burst per direction, FIXED/INCR/WRAP addressing.
module exin_axi_full_slave_mem #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 10
) (
  input logic                       ACLK,
  input logic                       ARESETN,
  exin_axi_full_slave_mem_if.slave  s
);
  localparam int WA    = C_S_AXI_ADDR_WIDTH - 2;
  localparam int DEPTH = 2 ** WA;
  localparam int NB    = C_S_AXI_DATA_WIDTH / 8;
  localparam logic [1:0] RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10;
  localparam logic [1:0] B_FIXED = 2'b00, B_INCR = 2'b01, B_WRAP = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

  logic [C_S_AXI_DATA_WIDTH-1:0] mem [DEPTH];

  function automatic logic is_illegal(input logic [1:0] b, input logic [7:0] l);
    return (b == 2'b11) || (b == B_WRAP && !(l == 8'd1 || l == 8'd3 || l == 8'd7 || l == 8'd15));
  endfunction

  // Illegal bursts run as INCR; the error is reported on the response instead.
  function automatic logic [1:0] eff_burst(input logic [1:0] b, input logic [7:0] l);
    return is_illegal(b, l) ? B_INCR : b;
  endfunction

  // Word-address step; a legal WRAP len is 2^n-1 so it doubles as the window mask.
  function automatic logic [WA-1:0] next_addr(input logic [WA-1:0] a, input logic [7:0] l,
                                              input logic [1:0] b);
    logic [WA-1:0] m;
    m = {{(WA-4){1'b0}}, l[3:0]};
    case (b)
      B_FIXED: return a;
      B_WRAP:  return (a & ~m) | ((a + 1'b1) & m);
      default: return a + 1'b1;
    endcase
  endfunction

  w_state_e w_state_q, w_state_d;
  logic awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d, werr_q, werr_d;
  logic [1:0] bresp_q, bresp_d, wburst_q, wburst_d;
  logic [WA-1:0] waddr_q, waddr_d;
  logic [7:0] wlen_q, wlen_d, wbeat_q, wbeat_d;
  logic mem_we, w_last_bad;

  r_state_e r_state_q, r_state_d;
  logic arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [1:0] rresp_q, rresp_d, rburst_q, rburst_d;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d, rd_word;
  logic [WA-1:0] raddr_q, raddr_d, rd_idx, ar_word;
  logic [7:0] rlen_q, rlen_d, rbeat_q, rbeat_d;

  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{s.S_AXI_AWADDR[1:0], s.S_AXI_ARADDR[1:0]};

  always_comb begin
    w_state_d = w_state_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    waddr_d   = waddr_q;
    wlen_d    = wlen_q;
    wburst_d  = wburst_q;
    wbeat_d   = wbeat_q;
    werr_d    = werr_q;
    mem_we    = 1'b0;
    w_last_bad = s.S_AXI_WLAST != (wbeat_q == wlen_q);
    case (w_state_q)
      W_IDLE: begin
        awready_d = 1'b1;
        if (s.S_AXI_AWVALID && awready_q) begin
          awready_d = 1'b0;
          wready_d  = 1'b1;
          w_state_d = W_DATA;
          waddr_d   = s.S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
          wlen_d    = s.S_AXI_AWLEN;
          wburst_d  = eff_burst(s.S_AXI_AWBURST, s.S_AXI_AWLEN);
          werr_d    = is_illegal(s.S_AXI_AWBURST, s.S_AXI_AWLEN);
          wbeat_d   = 8'd0;
        end
      end
      W_DATA: begin
        if (s.S_AXI_WVALID && wready_q) begin
          mem_we  = 1'b1;
          waddr_d = next_addr(waddr_q, wlen_q, wburst_q);
          wbeat_d = wbeat_q + 8'd1;
          werr_d  = werr_q | w_last_bad;
          // Beat count, not WLAST, terminates the burst.
          if (wbeat_q == wlen_q) begin
            wready_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = (werr_q || w_last_bad) ? RESP_SLVERR : RESP_OKAY;
            w_state_d = W_RESP;
          end
        end
      end
      W_RESP: begin
        if (s.S_AXI_BREADY && bvalid_q) begin
          bvalid_d  = 1'b0;
          bresp_d   = RESP_OKAY;
          awready_d = 1'b1;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Read-port address: the AR start word when idle, otherwise the next beat.
  assign ar_word = s.S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign rd_idx  = (r_state_q == R_IDLE) ? ar_word : raddr_q;
  assign rd_word = mem[rd_idx];

  always_comb begin
    r_state_d = r_state_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    raddr_d   = raddr_q;
    rlen_d    = rlen_q;
    rburst_d  = rburst_q;
    rbeat_d   = rbeat_q;
    case (r_state_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (s.S_AXI_ARVALID && arready_q) begin
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          rdata_d   = rd_word;
          rlast_d   = (s.S_AXI_ARLEN == 8'd0);
          rresp_d   = is_illegal(s.S_AXI_ARBURST, s.S_AXI_ARLEN) ? RESP_SLVERR : RESP_OKAY;
          rburst_d  = eff_burst(s.S_AXI_ARBURST, s.S_AXI_ARLEN);
          raddr_d   = next_addr(ar_word, s.S_AXI_ARLEN, rburst_d);
          rlen_d    = s.S_AXI_ARLEN;
          rbeat_d   = 8'd0;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (s.S_AXI_RREADY && rvalid_q) begin
          if (rlast_q) begin
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            rresp_d   = RESP_OKAY;
            rdata_d   = '0;
            arready_d = 1'b1;
            r_state_d = R_IDLE;
          end else begin
            rdata_d = rd_word;
            raddr_d = next_addr(raddr_q, rlen_q, rburst_q);
            rbeat_d = rbeat_q + 8'd1;
            rlast_d = (rbeat_q + 8'd1 == rlen_q);
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      waddr_q   <= '0;
      wlen_q    <= '0;
      wburst_q  <= '0;
      wbeat_q   <= '0;
      werr_q    <= 1'b0;
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
      raddr_q   <= '0;
      rlen_q    <= '0;
      rburst_q  <= '0;
      rbeat_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      waddr_q   <= waddr_d;
      wlen_q    <= wlen_d;
      wburst_q  <= wburst_d;
      wbeat_q   <= wbeat_d;
      werr_q    <= werr_d;
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      raddr_q   <= raddr_d;
      rlen_q    <= rlen_d;
      rburst_q  <= rburst_d;
      rbeat_q   <= rbeat_d;
    end
  end

  // Memory survives reset; writes are only suppressed while reset is asserted.
  always_ff @(posedge ACLK) begin
    if (ARESETN && mem_we) begin
      for (int b = 0; b < NB; b++)
        if (s.S_AXI_WSTRB[b]) mem[waddr_q][8*b +: 8] <= s.S_AXI_WDATA[8*b +: 8];
    end
  end

  assign s.S_AXI_AWREADY = awready_q;
  assign s.S_AXI_WREADY  = wready_q;
  assign s.S_AXI_BVALID  = bvalid_q;
  assign s.S_AXI_BRESP   = bresp_q;
  assign s.S_AXI_ARREADY = arready_q;
  assign s.S_AXI_RVALID  = rvalid_q;
  assign s.S_AXI_RLAST   = rlast_q;
  assign s.S_AXI_RRESP   = rresp_q;
  assign s.S_AXI_RDATA   = rdata_q;
endmodule

// File: tb/tb_exin_axi_full_slave_mem.sv
// Scoreboard bench for exin_axi_full_slave_mem: stimulus pushes expected B/R
// responses from a byte-address memory model; negedge monitors pop and compare.
module tb_exin_axi_full_slave_mem;
  logic ACLK = 1'b0;
  logic ARESETN = 1'b0;
  always #5 ACLK = ~ACLK;

  exin_axi_full_slave_mem_if #(.AW(10), .DW(32)) bus ();
  exin_axi_full_slave_mem #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(10)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .s(bus)
  );

  typedef struct { logic [31:0] d; logic [1:0] r; logic l; } rexp_t;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] mm [256];
  logic [31:0] wd [256];
  logic [3:0]  ws [256];
  logic [1:0]  bq [$];
  rexp_t       rq [$];
  bit rr_rand = 0, br_rand = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out / unexpected", nm);
  endtask

  function automatic bit illegal(input int b, input int l);
    return b == 3 || (b == 2 && !(l == 1 || l == 3 || l == 7 || l == 15));
  endfunction

  // Word index of beat i, derived from byte addresses and window arithmetic.
  function automatic int word_of(input int start, input int len, input int burst, input int i);
    int a, win, base, b;
    a = start & ~3;
    b = illegal(burst, len) ? 1 : burst;
    if (b == 0) begin
    end else if (b == 2) begin
      win  = (len + 1) * 4;
      base = (a / win) * win;
      a    = base + ((a - base) + 4 * i) % win;
    end else a = a + 4 * i;
    return (a / 4) % 256;
  endfunction

  // Writes wd/ws[0..len]; WLAST on beat bad_last (-1 = correct final beat).
  task automatic do_write(input int addr, input int len, input int burst, input int bad_last,
                          input bit gaps);
    int n, w;
    bit err;
    err = illegal(burst, len);
    for (int i = 0; i <= len; i++) begin
      w = word_of(addr, len, burst, i);
      for (int b = 0; b < 4; b++) if (ws[i][b]) mm[w][8*b +: 8] = wd[i][8*b +: 8];
      if ((bad_last < 0 ? (i == len) : (i == bad_last)) != (i == len)) err = 1;
    end
    bq.push_back(err ? 2'b10 : 2'b00);
    @(posedge ACLK); #1;
    bus.S_AXI_AWADDR  = addr[9:0];
    bus.S_AXI_AWLEN   = len[7:0];
    bus.S_AXI_AWBURST = burst[1:0];
    bus.S_AXI_AWVALID = 1'b1;
    n = 0;
    while (!bus.S_AXI_AWREADY && n < 100) begin @(posedge ACLK); #1; n++; end
    if (n >= 100) fail_now("aw_ready");
    @(posedge ACLK); #1;
    bus.S_AXI_AWVALID = 1'b0;
    for (int i = 0; i <= len; i++) begin
      bus.S_AXI_WDATA  = wd[i];
      bus.S_AXI_WSTRB  = ws[i];
      bus.S_AXI_WLAST  = (bad_last < 0) ? (i == len) : (i == bad_last);
      bus.S_AXI_WVALID = 1'b1;
      n = 0;
      while (!bus.S_AXI_WREADY && n < 100) begin @(posedge ACLK); #1; n++; end
      if (n >= 100) begin fail_now("w_ready"); break; end
      @(posedge ACLK); #1;
      bus.S_AXI_WVALID = 1'b0;
      bus.S_AXI_WLAST  = 1'b0;
      if (gaps && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) begin @(posedge ACLK); #1; end
    end
    n = 0;
    while (bq.size() > 0 && n < 500) begin @(posedge ACLK); #1; n++; end
    if (n >= 500) begin fail_now("b_resp"); bq.delete(); end
  endtask

  task automatic ar_only(input int addr, input int len, input int burst);
    int n;
    rexp_t e;
    for (int i = 0; i <= len; i++) begin
      e.d = mm[word_of(addr, len, burst, i)];
      e.r = illegal(burst, len) ? 2'b10 : 2'b00;
      e.l = (i == len);
      rq.push_back(e);
    end
    @(posedge ACLK); #1;
    bus.S_AXI_ARADDR  = addr[9:0];
    bus.S_AXI_ARLEN   = len[7:0];
    bus.S_AXI_ARBURST = burst[1:0];
    bus.S_AXI_ARVALID = 1'b1;
    n = 0;
    while (!bus.S_AXI_ARREADY && n < 100) begin @(posedge ACLK); #1; n++; end
    if (n >= 100) fail_now("ar_ready");
    @(posedge ACLK); #1;
    bus.S_AXI_ARVALID = 1'b0;
  endtask

  task automatic do_read(input int addr, input int len, input int burst);
    int n;
    ar_only(addr, len, burst);
    n = 0;
    while (rq.size() > 0 && n < 2000) begin @(posedge ACLK); #1; n++; end
    if (n >= 2000) begin fail_now("r_beats"); rq.delete(); end
  endtask

  // Monitors: handshakes seen at negedge complete on the next rising edge.
  bit pr_v, pb_v, pr_l;
  logic [31:0] pr_d;
  logic [1:0] pb_r;
  always @(negedge ACLK) begin
    rexp_t e;
    if (!ARESETN) begin
      pr_v = 0;
      pb_v = 0;
    end else begin
      if (pr_v) begin
        chk("r_hold_valid", bus.S_AXI_RVALID, 1);
        chk("r_hold_data", {bus.S_AXI_RLAST, bus.S_AXI_RDATA}, {pr_l, pr_d});
      end
      if (pb_v) chk("b_hold", {bus.S_AXI_BVALID, bus.S_AXI_BRESP}, {1'b1, pb_r});
      if (bus.S_AXI_RVALID && bus.S_AXI_RREADY) begin
        if (rq.size() == 0) fail_now("r_unexpected");
        else begin
          e = rq.pop_front();
          chk("rdata", bus.S_AXI_RDATA, e.d);
          chk("rresp_rlast", {bus.S_AXI_RRESP, bus.S_AXI_RLAST}, {e.r, e.l});
        end
      end
      if (bus.S_AXI_BVALID && bus.S_AXI_BREADY) begin
        if (bq.size() == 0) fail_now("b_unexpected");
        else chk("bresp", bus.S_AXI_BRESP, bq.pop_front());
      end
      pr_v = bus.S_AXI_RVALID && !bus.S_AXI_RREADY;
      pr_d = bus.S_AXI_RDATA;
      pr_l = bus.S_AXI_RLAST;
      pb_v = bus.S_AXI_BVALID && !bus.S_AXI_BREADY;
      pb_r = bus.S_AXI_BRESP;
    end
  end

  initial forever begin
    @(posedge ACLK); #1;
    if (rr_rand) bus.S_AXI_RREADY = ($urandom_range(0, 3) != 0);
    if (br_rand) bus.S_AXI_BREADY = ($urandom_range(0, 2) != 0);
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int len, burst, bad;
    bus.S_AXI_AWADDR = '0; bus.S_AXI_AWLEN = '0; bus.S_AXI_AWBURST = '0; bus.S_AXI_AWVALID = 0;
    bus.S_AXI_WDATA = '0; bus.S_AXI_WSTRB = '0; bus.S_AXI_WLAST = 0; bus.S_AXI_WVALID = 0;
    bus.S_AXI_BREADY = 1;
    bus.S_AXI_ARADDR = '0; bus.S_AXI_ARLEN = '0; bus.S_AXI_ARBURST = '0; bus.S_AXI_ARVALID = 0;
    bus.S_AXI_RREADY = 1;
    repeat (3) @(posedge ACLK);
    #1;
    chk("reset_outs", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_BVALID, bus.S_AXI_BRESP,
                       bus.S_AXI_ARREADY, bus.S_AXI_RVALID, bus.S_AXI_RLAST, bus.S_AXI_RRESP,
                       bus.S_AXI_RDATA}, 0);
    ARESETN = 1;
    @(posedge ACLK); #1;
    chk("ready_after_reset", {bus.S_AXI_AWREADY, bus.S_AXI_ARREADY}, 2'b11);

    // Fill the whole memory so every later read has defined data.
    for (int i = 0; i < 256; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    do_write(0, 255, 1, -1, 0);

    for (int i = 0; i < 4; i++) begin wd[i] = 32'hA0 + i; ws[i] = 4'hF; end
    do_write('h010, 3, 1, -1, 0);
    do_read('h010, 3, 1);

    for (int i = 0; i < 4; i++) begin wd[i] = i + 1; ws[i] = 4'hF; end
    do_write('h018, 3, 2, -1, 0);
    do_read('h010, 3, 1);

    wd[0] = 32'hFFFF_FFFF; ws[0] = 4'hF;
    do_write('h020, 0, 1, -1, 0);
    wd[0] = 32'h0; ws[0] = 4'b0101;
    do_write('h020, 0, 1, -1, 0);
    do_read('h020, 0, 1);
    for (int i = 0; i < 3; i++) begin wd[i] = 7 + i; ws[i] = 4'hF; end
    do_write('h024, 2, 0, -1, 0);
    do_read('h024, 0, 1);

    for (int i = 0; i < 4; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    do_write('h030, 3, 1, 1, 0);
    do_read('h030, 1, 3);
    do_read('h030, 3, 1);

    // Read stall mid-burst, then write-response stall.
    fork
      do_read('h040, 7, 1);
      begin
        repeat (5) @(posedge ACLK);
        #1 bus.S_AXI_RREADY = 0;
        repeat (3) @(posedge ACLK);
        #1 bus.S_AXI_RREADY = 1;
      end
    join
    bus.S_AXI_BREADY = 0;
    for (int i = 0; i < 2; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
    fork
      do_write('h050, 1, 1, -1, 0);
      begin
        int n = 0;
        while (!bus.S_AXI_BVALID && n < 100) begin @(posedge ACLK); #1; n++; end
        if (n >= 100) fail_now("bvalid_rise");
        repeat (5) begin @(posedge ACLK); #1; chk("bvalid_held", bus.S_AXI_BVALID, 1); end
        bus.S_AXI_BREADY = 1;
      end
    join

    // Reset while beat 2 of an 8-beat read is on the bus.
    ar_only('h080, 7, 1);
    repeat (2) @(posedge ACLK);
    #1 ARESETN = 0;
    @(posedge ACLK); #1;
    ARESETN = 1;
    chk("beats_before_rst", rq.size(), 6);
    chk("rvalid_after_rst", {bus.S_AXI_RVALID, bus.S_AXI_ARREADY}, 2'b00);
    rq.delete();
    @(posedge ACLK); #1;
    chk("arready_after_rst", bus.S_AXI_ARREADY, 1);
    do_read('h080, 7, 1);

    rr_rand = 1;
    br_rand = 1;
    for (int t = 0; t < 40; t++) begin
      len   = ($urandom_range(0, 7) == 0) ? $urandom_range(16, 40) : $urandom_range(0, 15);
      burst = $urandom_range(0, 3);
      bad   = ($urandom_range(0, 7) == 0) ? $urandom_range(0, len) : -1;
      for (int i = 0; i <= len; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
      do_write($urandom_range(0, 1023), len, burst, bad, 1);
      do_read($urandom_range(0, 1023), $urandom_range(0, 20), $urandom_range(0, 3));
    end
    rr_rand = 0;
    br_rand = 0;
    repeat (3) @(posedge ACLK);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
